// File: rtl/cache_tag_ctrl.sv
// Tag/state controller for a 2-way set-associative write-back cache.
// Handles lookups, victim selection, write-back and refill sequencing toward memory.
module cache_tag_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned N_WAYS      = 2,
  parameter int unsigned NUM_SETS    = 16,
  parameter int unsigned OFFSET_BITS = 7,
  parameter int unsigned INDEX_BITS  = 4,
  parameter int unsigned TAG_BITS    = 21
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [INDEX_BITS-1:0] req_index,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic                  resp_way,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_resp_valid,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  typedef enum logic [2:0] {
    StIdle, StLookup, StWbReq, StWbWait, StFillReq, StFillWait, StResp
  } state_e;

  state_e state_q, state_d;

  logic [NUM_SETS-1:0][N_WAYS-1:0] valid_q, dirty_q;
  logic [NUM_SETS-1:0]             lru_q;
  logic [TAG_BITS-1:0]             tags_q [NUM_SETS][N_WAYS];

  logic [TAG_BITS-1:0]   tag_q, victim_tag_q;
  logic [INDEX_BITS-1:0] index_q;
  logic                  write_q, victim_q;
  logic                  resp_hit_q, resp_way_q;
  logic [31:0]           hit_q, miss_q;

  logic [N_WAYS-1:0] set_valid, set_dirty;
  logic              hit0, hit1, hit, hit_way, victim, fill_done;

  assign set_valid = valid_q[index_q];
  assign set_dirty = dirty_q[index_q];
  assign hit0      = set_valid[0] && (tags_q[index_q][0] == tag_q);
  assign hit1      = set_valid[1] && (tags_q[index_q][1] == tag_q);
  assign hit       = hit0 | hit1;
  assign hit_way   = ~hit0;
  // Prefer an empty way; only fall back to LRU when the set is full.
  assign victim    = ~set_valid[0] ? 1'b0 : (~set_valid[1] ? 1'b1 : lru_q[index_q]);
  assign fill_done = (state_q == StFillWait) && mem_resp_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (req_valid) state_d = StLookup;
      StLookup: begin
        if (hit) begin
          state_d = StResp;
        end else if (set_valid[victim] && set_dirty[victim]) begin
          state_d = StWbReq;
        end else begin
          state_d = StFillReq;
        end
      end
      StWbReq:    if (mem_req_ready) state_d = StWbWait;
      StWbWait:   if (mem_resp_valid) state_d = StFillReq;
      StFillReq:  if (mem_req_ready) state_d = StFillWait;
      StFillWait: if (mem_resp_valid) state_d = StResp;
      StResp:     if (resp_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    unique case (state_q)
      StIdle:    req_ready = 1'b1;
      StResp:    resp_valid = 1'b1;
      StWbReq: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {victim_tag_q, index_q, {OFFSET_BITS{1'b0}}};
      end
      StFillReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag_q, index_q, {OFFSET_BITS{1'b0}}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
      tag_q        <= '0;
      index_q      <= '0;
      write_q      <= 1'b0;
      victim_q     <= 1'b0;
      victim_tag_q <= '0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      if (state_q == StIdle && req_valid) begin
        tag_q   <= req_tag;
        index_q <= req_index;
        write_q <= req_write;
      end
      if (state_q == StLookup) begin
        if (hit) begin
          lru_q[index_q] <= ~hit_way;
          if (write_q) dirty_q[index_q][hit_way] <= 1'b1;
          resp_hit_q <= 1'b1;
          resp_way_q <= hit_way;
          if (hit_q != '1) hit_q <= hit_q + 32'd1;
        end else begin
          victim_q     <= victim;
          victim_tag_q <= tags_q[index_q][victim];
          if (miss_q != '1) miss_q <= miss_q + 32'd1;
        end
      end
      if (fill_done) begin
        valid_q[index_q][victim_q] <= 1'b1;
        dirty_q[index_q][victim_q] <= write_q;
        lru_q[index_q]             <= ~victim_q;
        resp_hit_q                 <= 1'b0;
        resp_way_q                 <= victim_q;
      end
    end
  end

  // Tag storage needs no reset: a tag is only ever observed behind its valid bit.
  always_ff @(posedge clk) begin
    if (fill_done) tags_q[index_q][victim_q] <= tag_q;
  end

  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Self-checking bench for cache_tag_ctrl: directed vector table, hand-written reset/idle
// sequences, then random traffic scored against a set/way array model of the cache.
module tb_cache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [20:0] req_tag = '0;
  logic [3:0]  req_index = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_hit, resp_way;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  cache_tag_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_tag        (req_tag),
    .req_index      (req_index),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_hit       (resp_hit),
    .resp_way       (resp_way),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents of each set and way, plus per-set LRU way and event counts.
  logic        m_valid [16][2];
  logic        m_dirty [16][2];
  logic [20:0] m_tag   [16][2];
  logic        m_lru   [16];
  logic [31:0] m_hits, m_misses;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
      end
      m_lru[s] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  function automatic logic [31:0] blk(input logic [20:0] t, input logic [3:0] ix);
    return {t, ix, 7'b0};
  endfunction

  // One complete transaction: model prediction, handshake with a simple memory, and checks.
  task automatic txn(input logic w, input logic [20:0] t, input logic [3:0] ix,
                     input int stall, input int hold,
                     output logic got_hit, output logic got_way, output logic got_wb,
                     output logic [31:0] got_wb_addr, output logic [31:0] got_fill_addr);
    logic e_hit, e_way, e_wb, done, seen, first_we, order_ok, stable_ok;
    logic [31:0] e_wb_addr, e_fill_addr, first_addr;
    int lat, n, stall_left, pend, n_wb, n_fill;

    e_hit = 1'b0; e_way = 1'b0; e_wb = 1'b0; e_wb_addr = '0; e_fill_addr = '0;
    for (int k = 0; k < 2; k++) begin
      if (!e_hit && m_valid[ix][k] && m_tag[ix][k] == t) begin
        e_hit = 1'b1;
        e_way = k[0];
      end
    end
    if (e_hit) begin
      m_lru[ix] = ~e_way;
      if (w) m_dirty[ix][e_way] = 1'b1;
      if (m_hits != 32'hFFFF_FFFF) m_hits++;
    end else begin
      if (!m_valid[ix][0]) e_way = 1'b0;
      else if (!m_valid[ix][1]) e_way = 1'b1;
      else e_way = m_lru[ix];
      e_wb        = m_valid[ix][e_way] && m_dirty[ix][e_way];
      e_wb_addr   = blk(m_tag[ix][e_way], ix);
      e_fill_addr = blk(t, ix);
      m_valid[ix][e_way] = 1'b1;
      m_dirty[ix][e_way] = w;
      m_tag[ix][e_way]   = t;
      m_lru[ix]          = ~e_way;
      if (m_misses != 32'hFFFF_FFFF) m_misses++;
    end

    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_txn", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_tag = t; req_index = ix;
    @(negedge clk);
    // Scramble the request lines so any failure to capture them shows up.
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_tag   = 21'($urandom);
    req_index = 4'($urandom);

    lat = 1; done = 1'b0; seen = 1'b0; first_we = 1'b0; first_addr = '0;
    stall_left = 0; pend = 0; n_wb = 0; n_fill = 0; order_ok = 1'b1; stable_ok = 1'b1;
    got_wb_addr = '0; got_fill_addr = '0;
    while (!done && lat < 100) begin
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
      if (resp_valid) begin
        done = 1'b1;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) mem_resp_valid = 1'b1;
        end
        if (mem_req_valid) begin
          if (!seen) begin
            seen = 1'b1; first_addr = mem_req_addr; first_we = mem_req_we; stall_left = stall;
          end else if (mem_req_addr !== first_addr || mem_req_we !== first_we) begin
            stable_ok = 1'b0;
          end
          // Stray completion pulses while a request is pending must be ignored.
          mem_resp_valid = 1'($urandom_range(0, 1));
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            mem_req_ready = 1'b1;
            seen = 1'b0;
            pend = 2;
            if (first_we) begin
              n_wb++;
              got_wb_addr = first_addr;
              if (n_fill > 0) order_ok = 1'b0;
            end else begin
              n_fill++;
              got_fill_addr = first_addr;
            end
          end
        end
        @(negedge clk);
        lat++;
      end
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;

    got_hit = resp_hit;
    got_way = resp_way;
    got_wb  = (n_wb > 0);
    chk("resp_seen", 32'(done), 32'd1);
    chk("resp_hit", 32'(resp_hit), 32'(e_hit));
    chk("resp_way", 32'(resp_way), 32'(e_way));
    chk("wb_count", 32'(n_wb), 32'(e_wb));
    chk("fill_count", 32'(n_fill), 32'(!e_hit));
    chk("wb_before_fill", 32'(order_ok), 32'd1);
    chk("mem_req_stable", 32'(stable_ok), 32'd1);
    if (e_wb) chk("wb_addr", got_wb_addr, e_wb_addr);
    if (!e_hit) chk("fill_addr", got_fill_addr, e_fill_addr);
    if (e_hit) chk("hit_latency", 32'(lat), 32'd2);
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("resp_hold", {27'd0, resp_valid, req_ready, mem_req_valid, resp_hit, resp_way},
          {27'd0, 1'b1, 1'b0, 1'b0, got_hit, got_way});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("back_to_idle", {30'd0, req_ready, resp_valid}, 32'b10);
  endtask

  typedef struct {
    logic        w;
    logic [20:0] tag;
    logic [3:0]  idx;
    int          stall;
    int          hold;
    logic        hit;
    logic        way;
    logic        wb;
    logic [31:0] wb_addr;
    logic [31:0] fill_addr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic gh, gw, gb;
    logic [31:0] gwa, gfa;
    int n;

    //        w     tag    idx  stall hold hit   way   wb    wb_addr       fill_addr
    vecs[0] = '{1'b0, 21'h1, 4'd3, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_0980};
    vecs[1] = '{1'b0, 21'h1, 4'd3, 0, 5, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 21'h2, 4'd3, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_1180};
    vecs[3] = '{1'b0, 21'h3, 4'd3, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_1980};
    vecs[4] = '{1'b1, 21'h4, 4'd5, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_2280};
    vecs[5] = '{1'b0, 21'h5, 4'd5, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_2A80};
    vecs[6] = '{1'b0, 21'h6, 4'd5, 3, 0, 1'b0, 1'b0, 1'b1, 32'h0000_2280, 32'h0000_3280};
    vecs[7] = '{1'b1, 21'h5, 4'd5, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0};
    vecs[8] = '{1'b0, 21'h4, 4'd5, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0000_2280};
    vecs[9] = '{1'b0, 21'h1, 4'd3, 1, 0, 1'b0, 1'b1, 1'b1, 32'h0000_1180, 32'h0000_0980};

    model_reset();
    #1;
    chk("rst_handshake", {28'd0, req_ready, resp_valid, mem_req_valid, mem_req_we}, 32'b1000);
    chk("rst_resp", {30'd0, resp_hit, resp_way}, 32'd0);
    chk("rst_addr", mem_req_addr, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].w, vecs[i].tag, vecs[i].idx, vecs[i].stall, vecs[i].hold, gh, gw, gb, gwa, gfa);
      chk("tbl_hit", 32'(gh), 32'(vecs[i].hit));
      chk("tbl_way", 32'(gw), 32'(vecs[i].way));
      chk("tbl_wb", 32'(gb), 32'(vecs[i].wb));
      if (vecs[i].wb) chk("tbl_wb_addr", gwa, vecs[i].wb_addr);
      if (!vecs[i].hit) chk("tbl_fill_addr", gfa, vecs[i].fill_addr);
    end

    // A completion pulse while idle must not disturb anything.
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("idle_pulse", {30'd0, req_ready, mem_req_valid}, 32'b10);
    txn(1'b0, 21'h1, 4'd3, 0, 0, gh, gw, gb, gwa, gfa);
    chk("idle_pulse_hit", {30'd0, gh, gw}, 32'b11);

    // Reset while waiting for refill data.
    req_valid = 1'b1; req_write = 1'b0; req_tag = 21'h7; req_index = 4'd9;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fill_req_seen", {30'd0, mem_req_valid, mem_req_we}, 32'b10);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("in_fill_wait", {29'd0, req_ready, mem_req_valid, resp_valid}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async", {28'd0, req_ready, mem_req_valid, mem_req_we, resp_valid}, 32'b1000);
    chk("rst_async_cnt", hit_count | miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    txn(1'b0, 21'h7, 4'd9, 0, 0, gh, gw, gb, gwa, gfa);
    chk("post_rst_miss", 32'(gh), 32'd0);
    txn(1'b0, 21'h1, 4'd3, 0, 0, gh, gw, gb, gwa, gfa);
    chk("post_rst_miss2", 32'(gh), 32'd0);

    for (int i = 0; i < 250; i++) begin
      txn(1'($urandom_range(0, 1)), 21'($urandom_range(0, 4)), 4'($urandom_range(0, 2)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), gh, gw, gb, gwa, gfa);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
